// File: rtl/instr_sequencer.sv
// Fetch-and-step sequencer: fetches 9-bit instructions over req/ack, then walks the 4-phase step count.
// Optional single-step debug (WAIT state, step/step_mode ports) is enabled by defining SINGLE_STEP_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | stopped, waiting for run
// S_FETCH | mem_req high at PC, waiting for mem_ack
// S_EXEC  | count steps 00..11 over the latched instruction
// S_HALT  | HALT opcode fetched, waiting for run to resume at PC
// S_WAIT  | single-step only: instruction done, waiting for step
module instr_sequencer #(
  parameter int         ADDR_W  = 8,
  parameter logic [2:0] HALT_OP = 3'b110
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic              stop,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [8:0]        mem_data,
  output logic [8:0]        instr,
  output logic [1:0]        count,
  output logic              exec,
  output logic              busy,
  output logic              halted
`ifdef SINGLE_STEP_EN
  ,
  input  logic              step,
  input  logic              step_mode
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [8:0]          instr_nxt;
  logic [1:0]          count_nxt;

  assign mem_addr = pc;

  // Status outputs are registered from the next state so they line up with state.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr   <= '0;
      count   <= 2'b00;
      mem_req <= 1'b0;
      exec    <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr   <= instr_nxt;
      count   <= count_nxt;
      mem_req <= (state_nxt == S_FETCH);
      exec    <= (state_nxt == S_EXEC);
      busy    <= (state_nxt == S_FETCH) || (state_nxt == S_EXEC);
      halted  <= (state_nxt == S_HALT);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    count_nxt = 2'b00;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          instr_nxt = mem_data;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = (mem_data[8:6] == HALT_OP) ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (count == 2'b11) begin
          if (stop) begin
            state_nxt = S_IDLE;
          end
`ifdef SINGLE_STEP_EN
          else if (step_mode) begin
            state_nxt = S_WAIT;
          end
`endif
          else begin
            state_nxt = S_FETCH;
          end
        end else begin
          count_nxt = count + 2'd1;
        end
      end
      S_HALT: begin
        if (run) state_nxt = S_FETCH;
      end
`ifdef SINGLE_STEP_EN
      // stop takes priority over a coincident step so a debugger can always bail out.
      S_WAIT: begin
        if (stop)      state_nxt = S_IDLE;
        else if (step) state_nxt = S_FETCH;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: cycle model of the sequencing rules compared every cycle,
// plus directed literal checks for the program, wait-state, HALT, stop, wrap and reset cases.
module tb_instr_sequencer;
  localparam int ADDR_W = 8;
  localparam int MD_IDLE = 0, MD_FETCH = 1, MD_EXEC = 2, MD_HALT = 3, MD_WAIT = 4;

  logic              clock = 1'b0;
  logic              resetn, run, stop, mem_req, mem_ack, exec, busy, halted;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_data, instr;
  logic [1:0]        count;
`ifdef SINGLE_STEP_EN
  logic              step, step_mode;
`endif

  logic [8:0] mem [256];
  int         ack_delay, wait_cnt;
  logic       ack_force;
  int         errors = 0, checks = 0, cyc = 0;
  logic       cmp_on = 1'b0;

  int         m_mode, m_pc, m_step;
  logic [8:0] m_instr;

  always #5 clock = ~clock;

  instr_sequencer #(.ADDR_W(ADDR_W), .HALT_OP(3'b110)) dut (
    .clock(clock), .resetn(resetn), .run(run), .stop(stop),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .count(count), .exec(exec), .busy(busy), .halted(halted)
`ifdef SINGLE_STEP_EN
    , .step(step), .step_mode(step_mode)
`endif
  );

  assign mem_data = mem[mem_addr];
  assign mem_ack  = ack_force | (mem_req && (wait_cnt >= ack_delay));

  always @(posedge clock) begin
    if (resetn || !mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: what the sequencer is doing, in terms of PC, instruction and step number.
  always @(posedge clock) begin
    if (resetn) begin
      m_mode = MD_IDLE; m_pc = 0; m_instr = 9'h000; m_step = 0;
    end else begin
      case (m_mode)
        MD_IDLE:  if (run) m_mode = MD_FETCH;
        MD_FETCH: if (mem_ack) begin
          m_instr = mem[m_pc];
          m_pc    = (m_pc + 1) % 256;
          m_step  = 0;
          m_mode  = (m_instr[8:6] == 3'b110) ? MD_HALT : MD_EXEC;
        end
        MD_EXEC: if (m_step < 3) m_step++;
          else begin
            m_step = 0;
            if (stop) m_mode = MD_IDLE;
`ifdef SINGLE_STEP_EN
            else if (step_mode) m_mode = MD_WAIT;
`endif
            else m_mode = MD_FETCH;
          end
        MD_HALT: if (run) m_mode = MD_FETCH;
`ifdef SINGLE_STEP_EN
        MD_WAIT: if (stop) m_mode = MD_IDLE; else if (step) m_mode = MD_FETCH;
`endif
        default: m_mode = MD_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    cyc++;
    if (cmp_on) begin
      check("m_mem_req",  mem_req, m_mode == MD_FETCH);
      check("m_mem_addr", mem_addr, m_pc);
      check("m_instr",    instr, m_instr);
      check("m_count",    count, (m_mode == MD_EXEC) ? m_step : 0);
      check("m_exec",     exec, m_mode == MD_EXEC);
      check("m_busy",     busy, (m_mode == MD_FETCH) || (m_mode == MD_EXEC));
      check("m_halted",   halted, m_mode == MD_HALT);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_for_count(input int c, input string name);
    int n = 0;
    while (!(exec && count == 2'(c)) && n < 40) begin tick(); n++; end
    if (n >= 40) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    resetn = 1'b1; run = 1'b0; stop = 1'b0; ack_force = 1'b0; ack_delay = 0;
`ifdef SINGLE_STEP_EN
    step = 1'b0; step_mode = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = {3'b000, 6'(i)};
    mem[0] = 9'b000_001_010;
    mem[1] = 9'b001_011_100;
    mem[2] = 9'b110_000_000;
    mem[3] = 9'b010_101_011;
    repeat (2) tick();
    cmp_on = 1'b1;
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_instr", instr, 0);
    resetn = 1'b0;

    // stray ack while idle must be ignored
    tick(); ack_force = 1'b1;
    tick(); ack_force = 1'b0;
    check("stray_ack_busy", busy, 0);
    check("stray_ack_instr", instr, 0);

    // zero-wait program
    run = 1'b1;
    tick(); run = 1'b0;
    check("f0_req", mem_req, 1);
    check("f0_addr", mem_addr, 0);
    tick();
    check("add_instr", instr, 9'h00A);
    check("add_count0", count, 0);
    check("add_addr", mem_addr, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("add_count", count, k);
      check("add_instr_hold", instr, 9'h00A);
    end
    tick();
    check("f1_req", mem_req, 1);
    check("f1_addr", mem_addr, 1);
    tick();
    check("sub_instr", instr, 9'h05C);
    check("sub_count0", count, 0);
    ack_delay = 3;
    repeat (3) tick();

    // three wait states on the HALT fetch
    for (int w = 0; w < 4; w++) begin
      tick();
      check("ws_req", mem_req, 1);
      check("ws_addr", mem_addr, 2);
      check("ws_instr", instr, 9'h05C);
      check("ws_exec", exec, 0);
    end
    tick();
    ack_delay = 0;
    check("halt_halted", halted, 1);
    check("halt_exec", exec, 0);
    check("halt_pc", mem_addr, 3);
    check("halt_instr", instr, 9'h180);

    stop = 1'b1;
    repeat (2) tick();
    check("halt_stop_ignored", halted, 1);
    stop = 1'b0;
    run = 1'b1;
    tick(); run = 1'b0;
    check("resume_addr", mem_addr, 3);
    check("resume_req", mem_req, 1);

    // stop at count 01 completes the instruction
    tick();
    check("i3_instr", instr, 9'h0AB);
    tick();
    check("i3_count1", count, 1);
    stop = 1'b1;
    tick(); check("stop_count2", count, 2);
    tick(); check("stop_count3", count, 3);
    tick();
    check("stop_idle_busy", busy, 0);
    check("stop_idle_req", mem_req, 0);
    check("stop_idle_addr", mem_addr, 4);

    // run and stop together in IDLE: run wins
    run = 1'b1;
    tick(); run = 1'b0; stop = 1'b0;
    check("runwins_req", mem_req, 1);
    check("runwins_addr", mem_addr, 4);

    // run through the top of memory and check the PC wraps
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 8'd255) && n < 2000) begin tick(); n++; end
      if (n >= 2000) check("wrap_reach_timeout", 0, 1);
      n = 0;
      while (!(mem_req && mem_addr != 8'd255) && n < 20) begin tick(); n++; end
      if (n >= 20) check("wrap_next_timeout", 0, 1);
      check("wrap_addr", mem_addr, 0);
    end

    // reset asserted mid-exec at count 10
    wait_for_count(2, "rst_mid");
    resetn = 1'b1;
    tick(); resetn = 1'b0;
    check("midrst_req", mem_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    check("midrst_instr", instr, 0);
    check("midrst_addr", mem_addr, 0);

`ifdef SINGLE_STEP_EN
    step_mode = 1'b1;
    run = 1'b1;
    tick(); run = 1'b0;
    wait_for_count(3, "ss0");
    tick();
    for (int w = 0; w < 3; w++) begin
      check("ss_wait_busy", busy, 0);
      check("ss_wait_req", mem_req, 0);
      tick();
    end
    step = 1'b1;
    tick(); step = 1'b0;
    check("ss_step_req", mem_req, 1);
    check("ss_step_addr", mem_addr, 1);
    wait_for_count(3, "ss1");
    tick();
    check("ss_wait2_busy", busy, 0);
    stop = 1'b1;
    tick(); stop = 1'b0;
    run = 1'b1;
    tick(); run = 1'b0;
    check("ss_idle_run_req", mem_req, 1);
    check("ss_idle_run_addr", mem_addr, 2);
    step_mode = 1'b0;
    repeat (3) tick();
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
